ppu_render_sequencer: RTL and testbench
=======================================

Name: ppu_render_sequencer

Overview:
- Parametrised frame sequencer for the PPU render pipeline.
- Walks a frame line by line and tile by tile, handshaking (start pulse / busy) with three sub-engines: palette/colour load, sprite evaluation, and tile fetch/draw.
- Adds capabilities the first-generation sequencer lacks:
  - configurable geometry;
  - correct fine-X partial-tile handling;
  - optional per-line palette reload;
  - render-disable frame skip;
  - per-handshake watchdog timeout with error reporting.

Parameters:
- H_PIXELS, 256, visible pixels per line; must be a multiple of TILE_W.
- V_LINES, 240, visible lines per frame.
- TILE_W, 8, pixels per tile fetch; must be a power of two, at least 2.
- ROW_W, 9, width of pixel_row.
- COL_W, 9, width of pixel_col (two's complement).
- PALETTE_PER_LINE, 1, 1 = colour load before every line; 0 = colour load once per frame.
- TIMEOUT, 1023, maximum busy cycles allowed per handshake; 0 = watchdog disabled.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- vga_done  in  1  VGA finished reading frame memory; a frame may begin
- render_en  in  1  background/sprite rendering enabled; sampled at frame start
- fine_x  in  log2(TILE_W)  fine horizontal scroll; latched at frame start
- color_start  out  1  one-cycle start pulse to colour loader
- color_busy  in  1  colour loader busy
- sprite_start  out  1  one-cycle start pulse to sprite evaluator
- sprite_busy  in  1  sprite evaluator busy
- tile_start  out  1  one-cycle start pulse to tile engine
- tile_busy  in  1  tile engine busy
- pixel_row  out  ROW_W  current screen line
- pixel_col  out  COL_W  screen column of leftmost pixel of current tile (may be negative)
- vblank  out  1  frame rendered, waiting on VGA
- frame_done  out  1  one-cycle pulse on VBLANK entry
- frame_count  out  8  completed frames, wraps 255->0
- timeout_err  out  1  sticky watchdog flag, cleared at next frame start

Behaviour:
- Reset: rst sampled on the clk edge only; one cycle is sufficient. State = IDLE; every output = 0; internal counters and latches = 0. Reset mid-handshake abandons it with no further start pulses; sub-engines are reset by the same rst.
- Handshake rule (every *_start): pulse is exactly one cycle. The next cycle is an ARM cycle; busy is ignored. From the following cycle on, the sequencer waits for busy=0. Sub-engines must raise busy within 1 cycle of start.
- Watchdog:
  - While waiting on busy, a counter increments each cycle.
  - If it reaches TIMEOUT (TIMEOUT>0), set timeout_err and treat the engine as done.
  - The counter clears on each start.
- Tiles per line: TPL = H_PIXELS/TILE_W + (fine_x_l != 0).
- Column arithmetic: pixel_col = tile_idx*TILE_W - fine_x_l, modulo 2^COL_W. Example: fine_x=3 gives first col = -3 (0x1FD at COL_W=9), then 5, 13, ...
- States and transitions:
  - IDLE: vblank=0. When vga_done=1:
    - latch fine_x_l and render_en; clear timeout_err; row=0; tile_idx=0.
    - render_en=1 → COLOR.
    - render_en=0 → VBLANK directly (no start pulses).
  - COLOR: pulse color_start, ARM, wait; then → SPRITE.
  - SPRITE: pulse sprite_start, ARM, wait; then → TILE.
  - TILE: pulse tile_start, ARM, wait. On completion:
    - if tile_idx < TPL-1: tile_idx+1, → TILE.
    - else if row < V_LINES-1: row+1, tile_idx=0, → COLOR (PALETTE_PER_LINE=1) or SPRITE (=0).
    - else → VBLANK.
  - VBLANK:
    - on entry: frame_done pulses for 1 cycle; frame_count+1.
    - vblank=1 while in this state.
    - when vga_done=0 → IDLE.
- pixel_row and pixel_col are stable from a start pulse until that engine's busy falls; they update only on the transitions above.
- Simultaneous events: vga_done is ignored outside IDLE and VBLANK. If vga_done is still 1 on VBLANK entry, remain in VBLANK until it falls; at most one frame per vga_done rising period.
- Frame timing: one frame takes at least 3 cycles per handshake (pulse, ARM, done) plus engine latency.

Test Plan:
- H_PIXELS=16, V_LINES=2, TILE_W=8, fine_x=0, all engines busy for 2 cycles, vga_done 0→1 → 2 color_start, 2 sprite_start, 4 tile_start; cols 0,8 per line; frame_done once; frame_count=1; vblank=1 until vga_done=0.
- Same geometry, fine_x=3 → 3 tile_start per line; pixel_col 0x1FD, 5, 13.
- render_en=0 at vga_done rise → no start pulses; frame_done the following cycle; frame_count increments.
- TIMEOUT=5, tile_busy stuck high → timeout_err=1 after 5 wait cycles; sequencing continues; flag clears at next frame start.
- PALETTE_PER_LINE=0, V_LINES=3 → exactly 1 color_start, 3 sprite_start per frame.
- rst asserted 1 cycle during a TILE wait → next cycle all outputs 0, state IDLE; with vga_done held 1, a new frame starts with row 0.

Source files
------------

// File: rtl/ppu_render_sequencer_if.sv
// Start/busy handshake bundle between the render sequencer and its three sub-engines.
// A start pulse lasts exactly one cycle. Busy is ignored in the following (ARM) cycle,
// and the sequencer then waits for busy to drop; engines must raise busy within 1 cycle of start.
interface ppu_render_sequencer_if;
  logic color_start;
  logic color_busy;
  logic sprite_start;
  logic sprite_busy;
  logic tile_start;
  logic tile_busy;

  modport master (
    output color_start, sprite_start, tile_start,
    input  color_busy, sprite_busy, tile_busy
  );

  modport slave (
    input  color_start, sprite_start, tile_start,
    output color_busy, sprite_busy, tile_busy
  );
endinterface

// File: rtl/ppu_render_sequencer.sv
// Frame sequencer: walks lines and tiles, handshaking with the colour, sprite and tile engines,
// with fine-X partial tiles, optional per-line palette reload and a per-handshake watchdog.
module ppu_render_sequencer #(
  parameter int H_PIXELS         = 256,
  parameter int V_LINES          = 240,
  parameter int TILE_W           = 8,
  parameter int ROW_W            = 9,
  parameter int COL_W            = 9,
  parameter int PALETTE_PER_LINE = 1,
  parameter int TIMEOUT          = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  ppu_render_sequencer_if.master    eng,
  input  logic                      vga_done,
  input  logic                      render_en,
  input  logic [$clog2(TILE_W)-1:0] fine_x,
  output logic [ROW_W-1:0]          pixel_row,
  output logic [COL_W-1:0]          pixel_col,
  output logic                      vblank,
  output logic                      frame_done,
  output logic [7:0]                frame_count,
  output logic                      timeout_err,
  output logic [2:0]                dbg_state
);

  localparam int FX_W  = $clog2(TILE_W);
  localparam int TILES = H_PIXELS / TILE_W;
  localparam int TI_W  = $clog2(TILES + 1);
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TI_W-1:0]  LAST_NOFX  = TI_W'(TILES - 1);
  localparam logic [TI_W-1:0]  LAST_FX    = TI_W'(TILES);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(V_LINES - 1);
  localparam logic [COL_W-1:0] COL_STEP   = COL_W'(TILE_W);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_COLOR  = 3'd1,
    S_SPRITE = 3'd2,
    S_TILE   = 3'd3,
    S_VBLANK = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PH_START = 2'd0,
    PH_ARM   = 2'd1,
    PH_WAIT  = 2'd2
  } phase_t;

  state_t          state;
  phase_t          phase;
  logic [WD_W-1:0] wd_cnt;
  logic [TI_W-1:0] tile_idx;
  logic [FX_W-1:0] fine_x_l;

  logic cur_busy;
  logic wd_fire;
  logic hs_done;
  logic last_tile;

  always_comb begin
    cur_busy = 1'b0;
    case (state)
      S_COLOR:  cur_busy = eng.color_busy;
      S_SPRITE: cur_busy = eng.sprite_busy;
      S_TILE:   cur_busy = eng.tile_busy;
      default:  cur_busy = 1'b0;
    endcase
  end

  // A watchdog expiry completes the handshake exactly like busy falling.
  assign wd_fire   = (TIMEOUT != 0) && (wd_cnt == WD_LAST);
  assign hs_done   = (phase == PH_WAIT) && (!cur_busy || wd_fire);
  assign last_tile = (tile_idx == ((fine_x_l != '0) ? LAST_FX : LAST_NOFX));
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      phase           <= PH_START;
      wd_cnt          <= '0;
      tile_idx        <= '0;
      fine_x_l        <= '0;
      pixel_row       <= '0;
      pixel_col       <= '0;
      vblank          <= 1'b0;
      frame_done      <= 1'b0;
      frame_count     <= '0;
      timeout_err     <= 1'b0;
      eng.color_start  <= 1'b0;
      eng.sprite_start <= 1'b0;
      eng.tile_start   <= 1'b0;
    end else begin
      eng.color_start  <= 1'b0;
      eng.sprite_start <= 1'b0;
      eng.tile_start   <= 1'b0;
      frame_done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (vga_done) begin
            fine_x_l    <= fine_x;
            timeout_err <= 1'b0;
            pixel_row   <= '0;
            tile_idx    <= '0;
            pixel_col   <= COL_W'(0) - COL_W'(fine_x);
            phase       <= PH_START;
            if (render_en) begin
              state           <= S_COLOR;
              eng.color_start <= 1'b1;
            end else begin
              state       <= S_VBLANK;
              vblank      <= 1'b1;
              frame_done  <= 1'b1;
              frame_count <= frame_count + 8'd1;
            end
          end
        end
        S_COLOR, S_SPRITE, S_TILE: begin
          case (phase)
            PH_START: begin
              phase  <= PH_ARM;
              wd_cnt <= '0;
            end
            PH_ARM: phase <= PH_WAIT;
            default: begin
              if (hs_done) begin
                if (cur_busy) timeout_err <= 1'b1;
                phase <= PH_START;
                if (state == S_COLOR) begin
                  state            <= S_SPRITE;
                  eng.sprite_start <= 1'b1;
                end else if (state == S_SPRITE) begin
                  state          <= S_TILE;
                  eng.tile_start <= 1'b1;
                end else if (!last_tile) begin
                  tile_idx       <= tile_idx + TI_W'(1);
                  pixel_col      <= pixel_col + COL_STEP;
                  eng.tile_start <= 1'b1;
                end else if (pixel_row != ROW_LAST) begin
                  pixel_row <= pixel_row + ROW_W'(1);
                  tile_idx  <= '0;
                  pixel_col <= COL_W'(0) - COL_W'(fine_x_l);
                  if (PALETTE_PER_LINE != 0) begin
                    state           <= S_COLOR;
                    eng.color_start <= 1'b1;
                  end else begin
                    state            <= S_SPRITE;
                    eng.sprite_start <= 1'b1;
                  end
                end else begin
                  state       <= S_VBLANK;
                  vblank      <= 1'b1;
                  frame_done  <= 1'b1;
                  frame_count <= frame_count + 8'd1;
                end
              end else begin
                wd_cnt <= wd_cnt + WD_W'(1);
              end
            end
          endcase
        end
        S_VBLANK: begin
          // Holding here until vga_done falls gives one frame per vga_done period.
          if (!vga_done) begin
            state  <= S_IDLE;
            vblank <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_render_sequencer.sv
// Directed bench for ppu_render_sequencer: two instances (per-line palette with a 5-cycle
// watchdog, and once-per-frame palette over three lines) driven against simple busy engines.
module tb_ppu_render_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vga_done_a = 1'b0;
  logic       vga_done_b = 1'b0;
  logic       render_en = 1'b1;
  logic [2:0] fine_x = 3'd0;
  logic       stuck_a = 1'b0;

  logic [8:0] pixel_row_a, pixel_row_b;
  logic [8:0] pixel_col_a, pixel_col_b;
  logic       vblank_a, vblank_b;
  logic       frame_done_a, frame_done_b;
  logic [7:0] frame_count_a, frame_count_b;
  logic       timeout_err_a, timeout_err_b;
  logic [2:0] dbg_state_a, dbg_state_b;

  int n_pass  = 0;
  int n_total = 0;

  ppu_render_sequencer_if bus_a ();
  ppu_render_sequencer_if bus_b ();

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  ppu_render_sequencer #(
    .H_PIXELS(16), .V_LINES(2), .TILE_W(8), .ROW_W(9), .COL_W(9),
    .PALETTE_PER_LINE(1), .TIMEOUT(5)
  ) dut_a (
    .clk(clk), .rst(rst), .eng(bus_a.master),
    .vga_done(vga_done_a), .render_en(render_en), .fine_x(fine_x),
    .pixel_row(pixel_row_a), .pixel_col(pixel_col_a), .vblank(vblank_a),
    .frame_done(frame_done_a), .frame_count(frame_count_a),
    .timeout_err(timeout_err_a), .dbg_state(dbg_state_a)
  );

  ppu_render_sequencer #(
    .H_PIXELS(16), .V_LINES(3), .TILE_W(8), .ROW_W(9), .COL_W(9),
    .PALETTE_PER_LINE(0), .TIMEOUT(5)
  ) dut_b (
    .clk(clk), .rst(rst), .eng(bus_b.master),
    .vga_done(vga_done_b), .render_en(render_en), .fine_x(fine_x),
    .pixel_row(pixel_row_b), .pixel_col(pixel_col_b), .vblank(vblank_b),
    .frame_done(frame_done_b), .frame_count(frame_count_b),
    .timeout_err(timeout_err_b), .dbg_state(dbg_state_b)
  );

  // ---------------- engine models: busy for 2 cycles after start ----------------
  logic [1:0] ccnt_a = 2'd0, scnt_a = 2'd0, tcnt_a = 2'd0;
  logic [1:0] ccnt_b = 2'd0, scnt_b = 2'd0, tcnt_b = 2'd0;

  always @(posedge clk) begin
    if (rst) begin
      ccnt_a <= 2'd0; scnt_a <= 2'd0; tcnt_a <= 2'd0;
      ccnt_b <= 2'd0; scnt_b <= 2'd0; tcnt_b <= 2'd0;
    end else begin
      ccnt_a <= bus_a.color_start  ? 2'd2 : ((ccnt_a != 2'd0) ? ccnt_a - 2'd1 : 2'd0);
      scnt_a <= bus_a.sprite_start ? 2'd2 : ((scnt_a != 2'd0) ? scnt_a - 2'd1 : 2'd0);
      tcnt_a <= bus_a.tile_start   ? 2'd2 : ((tcnt_a != 2'd0) ? tcnt_a - 2'd1 : 2'd0);
      ccnt_b <= bus_b.color_start  ? 2'd2 : ((ccnt_b != 2'd0) ? ccnt_b - 2'd1 : 2'd0);
      scnt_b <= bus_b.sprite_start ? 2'd2 : ((scnt_b != 2'd0) ? scnt_b - 2'd1 : 2'd0);
      tcnt_b <= bus_b.tile_start   ? 2'd2 : ((tcnt_b != 2'd0) ? tcnt_b - 2'd1 : 2'd0);
    end
  end

  assign bus_a.color_busy  = (ccnt_a != 2'd0);
  assign bus_a.sprite_busy = (scnt_a != 2'd0);
  assign bus_a.tile_busy   = (tcnt_a != 2'd0) || stuck_a;
  assign bus_b.color_busy  = (ccnt_b != 2'd0);
  assign bus_b.sprite_busy = (scnt_b != 2'd0);
  assign bus_b.tile_busy   = (tcnt_b != 2'd0);

  // ---------------- pulse monitors ----------------
  int cs_a = 0, ss_a = 0, ts_a = 0, fd_a = 0;
  int cs_b = 0, ss_b = 0, ts_b = 0;
  logic [8:0] col_log_a [0:255];
  logic [8:0] row_log_a [0:255];

  always @(negedge clk) begin
    if (bus_a.color_start)  cs_a++;
    if (bus_a.sprite_start) ss_a++;
    if (bus_a.tile_start) begin
      if (ts_a < 256) begin
        col_log_a[ts_a] = pixel_col_a;
        row_log_a[ts_a] = pixel_row_a;
      end
      ts_a++;
    end
    if (frame_done_a) fd_a++;
    if (bus_b.color_start)  cs_b++;
    if (bus_b.sprite_start) ss_b++;
    if (bus_b.tile_start)   ts_b++;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_vblank(input bit which_b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ((which_b ? vblank_b : vblank_a) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    step(2);
    n_total++; if ({bus_a.color_start, bus_a.sprite_start, bus_a.tile_start} !== 3'b000)
      $display("FAIL reset_starts: got %b exp 000", {bus_a.color_start, bus_a.sprite_start, bus_a.tile_start}); else n_pass++;
    n_total++; if (pixel_row_a !== 9'd0) $display("FAIL reset_row: got %0h exp 0", pixel_row_a); else n_pass++;
    n_total++; if (pixel_col_a !== 9'd0) $display("FAIL reset_col: got %0h exp 0", pixel_col_a); else n_pass++;
    n_total++; if ({vblank_a, frame_done_a, timeout_err_a} !== 3'b000)
      $display("FAIL reset_flags: got %b exp 000", {vblank_a, frame_done_a, timeout_err_a}); else n_pass++;
    n_total++; if (frame_count_a !== 8'd0) $display("FAIL reset_frame_count: got %0d exp 0", frame_count_a); else n_pass++;
    n_total++; if (dbg_state_a !== 3'd0) $display("FAIL reset_state: got %0d exp 0", dbg_state_a); else n_pass++;
    n_total++; if (dbg_state_b !== 3'd0) $display("FAIL reset_state_b: got %0d exp 0", dbg_state_b); else n_pass++;
    rst = 1'b0;
    step(2);
  endtask

  task automatic run_frame_a(input logic [2:0] fx, input int exp_tiles,
                             input logic [8:0] c0, input logic [8:0] c1, input logic [8:0] c2,
                             input logic [7:0] exp_fc, input string tag);
    bit ok;
    int b_cs, b_ss, b_ts, b_fd;
    logic [8:0] exp_col [3];
    int tpl;
    exp_col[0] = c0; exp_col[1] = c1; exp_col[2] = c2;
    tpl = exp_tiles / 2;
    b_cs = cs_a; b_ss = ss_a; b_ts = ts_a; b_fd = fd_a;
    fine_x = fx;
    render_en = 1'b1;
    vga_done_a = 1'b1;
    wait_vblank(1'b0, ok);
    n_total++; if (!ok) $display("FAIL %s_vblank_wait: got no vblank exp vblank", tag); else n_pass++;
    step(1);
    n_total++; if (cs_a - b_cs !== 2) $display("FAIL %s_color_starts: got %0d exp 2", tag, cs_a - b_cs); else n_pass++;
    n_total++; if (ss_a - b_ss !== 2) $display("FAIL %s_sprite_starts: got %0d exp 2", tag, ss_a - b_ss); else n_pass++;
    n_total++; if (ts_a - b_ts !== exp_tiles) $display("FAIL %s_tile_starts: got %0d exp %0d", tag, ts_a - b_ts, exp_tiles); else n_pass++;
    for (int i = 0; i < exp_tiles; i++) begin
      n_total++; if (col_log_a[b_ts + i] !== exp_col[i % tpl])
        $display("FAIL %s_col%0d: got %0h exp %0h", tag, i, col_log_a[b_ts + i], exp_col[i % tpl]); else n_pass++;
      n_total++; if (row_log_a[b_ts + i] !== 9'(i / tpl))
        $display("FAIL %s_row%0d: got %0d exp %0d", tag, i, row_log_a[b_ts + i], i / tpl); else n_pass++;
    end
    n_total++; if (frame_count_a !== exp_fc) $display("FAIL %s_frame_count: got %0d exp %0d", tag, frame_count_a, exp_fc); else n_pass++;
    step(5);
    n_total++; if (vblank_a !== 1'b1) $display("FAIL %s_vblank_hold: got %b exp 1", tag, vblank_a); else n_pass++;
    n_total++; if (fd_a - b_fd !== 1) $display("FAIL %s_frame_done_count: got %0d exp 1", tag, fd_a - b_fd); else n_pass++;
    vga_done_a = 1'b0;
    step(2);
    n_total++; if ({vblank_a, dbg_state_a} !== 4'b0000)
      $display("FAIL %s_back_to_idle: got %b exp 0000", tag, {vblank_a, dbg_state_a}); else n_pass++;
  endtask

  task automatic test_basic_frame();
    run_frame_a(3'd0, 4, 9'h000, 9'h008, 9'h000, 8'd1, "basic");
  endtask

  task automatic test_fine_x();
    run_frame_a(3'd3, 6, 9'h1FD, 9'h005, 9'h00D, 8'd2, "finex");
    fine_x = 3'd0;
  endtask

  task automatic test_render_off();
    int b_cs, b_ss, b_ts;
    b_cs = cs_a; b_ss = ss_a; b_ts = ts_a;
    render_en = 1'b0;
    vga_done_a = 1'b1;
    step(1);
    n_total++; if ({frame_done_a, vblank_a} !== 2'b11)
      $display("FAIL off_frame_done: got %b exp 11", {frame_done_a, vblank_a}); else n_pass++;
    n_total++; if (frame_count_a !== 8'd3) $display("FAIL off_frame_count: got %0d exp 3", frame_count_a); else n_pass++;
    step(1);
    n_total++; if (frame_done_a !== 1'b0) $display("FAIL off_pulse_width: got %b exp 0", frame_done_a); else n_pass++;
    step(1);
    n_total++; if ((cs_a - b_cs) + (ss_a - b_ss) + (ts_a - b_ts) !== 0)
      $display("FAIL off_no_starts: got %0d exp 0", (cs_a - b_cs) + (ss_a - b_ss) + (ts_a - b_ts)); else n_pass++;
    vga_done_a = 1'b0;
    render_en = 1'b1;
    step(2);
  endtask

  task automatic test_timeout();
    bit ok;
    bit seen;
    int b_ts;
    b_ts = ts_a;
    stuck_a = 1'b1;
    vga_done_a = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_a.tile_start === 1'b1) begin seen = 1'b1; break; end
    end
    n_total++; if (!seen) $display("FAIL wd_tile_start_wait: got none exp tile_start"); else n_pass++;
    step(6);
    n_total++; if (timeout_err_a !== 1'b0) $display("FAIL wd_early: got %b exp 0", timeout_err_a); else n_pass++;
    step(1);
    n_total++; if (timeout_err_a !== 1'b1) $display("FAIL wd_set: got %b exp 1", timeout_err_a); else n_pass++;
    wait_vblank(1'b0, ok);
    n_total++; if (!ok) $display("FAIL wd_vblank_wait: got no vblank exp vblank"); else n_pass++;
    step(1);
    n_total++; if (ts_a - b_ts !== 4) $display("FAIL wd_tiles_continue: got %0d exp 4", ts_a - b_ts); else n_pass++;
    n_total++; if ({timeout_err_a, frame_count_a} !== {1'b1, 8'd4})
      $display("FAIL wd_sticky: got %b/%0d exp 1/4", timeout_err_a, frame_count_a); else n_pass++;
    stuck_a = 1'b0;
    vga_done_a = 1'b0;
    step(2);
    n_total++; if (timeout_err_a !== 1'b1) $display("FAIL wd_sticky_idle: got %b exp 1", timeout_err_a); else n_pass++;
    vga_done_a = 1'b1;
    step(1);
    n_total++; if ({timeout_err_a, dbg_state_a} !== {1'b0, 3'd1})
      $display("FAIL wd_clear_on_start: got %b exp 0001", {timeout_err_a, dbg_state_a}); else n_pass++;
    wait_vblank(1'b0, ok);
    n_total++; if ({ok, timeout_err_a, frame_count_a} !== {1'b1, 1'b0, 8'd5})
      $display("FAIL wd_clean_frame: got %b exp 1000000101", {ok, timeout_err_a, frame_count_a}); else n_pass++;
    vga_done_a = 1'b0;
    step(2);
  endtask

  task automatic test_palette_once();
    bit ok;
    int b_cs, b_ss, b_ts;
    b_cs = cs_b; b_ss = ss_b; b_ts = ts_b;
    fine_x = 3'd0;
    vga_done_b = 1'b1;
    wait_vblank(1'b1, ok);
    n_total++; if (!ok) $display("FAIL pal_vblank_wait: got no vblank exp vblank"); else n_pass++;
    step(1);
    n_total++; if (cs_b - b_cs !== 1) $display("FAIL pal_color_starts: got %0d exp 1", cs_b - b_cs); else n_pass++;
    n_total++; if (ss_b - b_ss !== 3) $display("FAIL pal_sprite_starts: got %0d exp 3", ss_b - b_ss); else n_pass++;
    n_total++; if (ts_b - b_ts !== 6) $display("FAIL pal_tile_starts: got %0d exp 6", ts_b - b_ts); else n_pass++;
    n_total++; if (frame_count_b !== 8'd1) $display("FAIL pal_frame_count: got %0d exp 1", frame_count_b); else n_pass++;
    vga_done_b = 1'b0;
    step(2);
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    int b_cs, b_ts;
    vga_done_a = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus_a.tile_start === 1'b1 && pixel_row_a === 9'd1) begin seen = 1'b1; break; end
    end
    n_total++; if (!seen) $display("FAIL rmid_row1_wait: got none exp row1 tile_start"); else n_pass++;
    step(2);
    rst = 1'b1;
    step(1);
    n_total++; if ({bus_a.color_start, bus_a.sprite_start, bus_a.tile_start, vblank_a, frame_done_a, timeout_err_a} !== 6'd0)
      $display("FAIL rmid_flags: got %b exp 000000",
               {bus_a.color_start, bus_a.sprite_start, bus_a.tile_start, vblank_a, frame_done_a, timeout_err_a}); else n_pass++;
    n_total++; if ({pixel_row_a, pixel_col_a} !== 18'd0)
      $display("FAIL rmid_row_col: got %0h/%0h exp 0/0", pixel_row_a, pixel_col_a); else n_pass++;
    n_total++; if ({frame_count_a, dbg_state_a} !== 11'd0)
      $display("FAIL rmid_count_state: got %0d/%0d exp 0/0", frame_count_a, dbg_state_a); else n_pass++;
    rst = 1'b0;
    b_cs = cs_a; b_ts = ts_a;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_a.color_start === 1'b1) begin seen = 1'b1; break; end
    end
    n_total++; if (!seen || pixel_row_a !== 9'd0)
      $display("FAIL rmid_restart_row: got seen=%b row=%0d exp seen=1 row=0", seen, pixel_row_a); else n_pass++;
    wait_vblank(1'b0, ok);
    step(1);
    n_total++; if (!ok || cs_a - b_cs !== 2 || ts_a - b_ts !== 4)
      $display("FAIL rmid_full_frame: got ok=%b colors=%0d tiles=%0d exp ok=1 colors=2 tiles=4",
               ok, cs_a - b_cs, ts_a - b_ts); else n_pass++;
    n_total++; if (frame_count_a !== 8'd1) $display("FAIL rmid_frame_count: got %0d exp 1", frame_count_a); else n_pass++;
    vga_done_a = 1'b0;
    step(2);
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_basic_frame();
    test_fine_x();
    test_render_off();
    test_timeout();
    test_palette_once();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
